pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush controller for the six-stage pipeline (IF, ID, EX, M1, M2, WB). It watches load-use hazards, EX branch redirects, M1 traps and the instruction- and data-memory ready handshakes. From these it drives the per-stage stall and flush inputs of every inter-stage pipeline register, plus the fetch-PC redirect. It holds a small FSM that covers data-memory wait and post-trap drain.

## Interface
Parameters:
- DRAIN_CYCLES, 2: bubble cycles inserted after a trap redirect while CSR state settles. 0 disables the drain.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- id_rs1, id_rs2  in  5  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2
- ex_rd, m1_rd  in  5  destinations in EX / M1
- ex_is_load, m1_is_load  in  1  EX / M1 instruction is a load
- ex_redirect  in  1  EX resolved a taken branch or jump (mispredict)
- ex_target  in  32  EX redirect PC
- m1_trap  in  1  M1 raises a trap or executes mret
- m1_trap_target  in  32  trap/return PC from CSR unit
- m1_mem_access  in  1  M1 holds a load/store issuing to dmem
- dmem_ready  in  1  dmem accepted/completed the M1 access this cycle
- imem_ready  in  1  imem returned the IF fetch this cycle
- stall_if, stall_id, stall_ex, stall_m1  out  1  hold the PC / register feeding ID / EX / M1 / M2
- flush_id, flush_ex, flush_m1, flush_m2  out  1  zero the register feeding that stage on the next edge
- pc_redirect  out  1  load pc_target into the fetch PC this edge
- pc_target  out  32  redirect PC

## Operation
- States: RUN, DMEM_WAIT, TRAP_DRAIN. Reset enters RUN with the drain counter at 0.
- All outputs are combinational from state and inputs. While rst is high, every output is 0.
- Only the active condition with the highest priority acts in a cycle. Priority order: dmem wait, trap, EX redirect, load-use, imem wait.
- Dmem wait applies when m1_mem_access=1 and dmem_ready=0, in RUN or DMEM_WAIT.
  - Outputs: stall_if, stall_id, stall_ex, stall_m1 = 1; flush_m2 = 1.
  - Next state is DMEM_WAIT.
  - DMEM_WAIT returns to RUN in the cycle dmem_ready=1. That cycle behaves as RUN.
- Trap applies when m1_trap=1 and there is no dmem wait.
  - Outputs: flush_id, flush_ex, flush_m1 = 1; pc_redirect = 1; pc_target = m1_trap_target.
  - The trapping instruction itself continues to M2.
  - Next state is TRAP_DRAIN with the counter = DRAIN_CYCLES-1. If DRAIN_CYCLES = 0, next state is RUN.
- EX redirect: outputs flush_id, flush_ex = 1; pc_redirect = 1; pc_target = ex_target.
- Load-use: a hazard exists when id_use_rsN=1, id_rsN≠0, and id_rsN matches a pending load destination.
  - Pending loads are ex_rd with ex_is_load=1, or m1_rd with m1_is_load=1.
  - Loads forward only from WB, so an EX load costs 2 bubbles and an M1 load costs 1.
  - Outputs: stall_if, stall_id = 1; flush_ex = 1.
  - The stall is re-evaluated every cycle. No state is kept.
- Imem wait applies when imem_ready=0. Outputs: stall_if = 1; flush_id = 1.
- TRAP_DRAIN:
  - Outputs: stall_if = 1; flush_id = 1.
  - ex_redirect, load-use and imem wait are ignored.
  - The counter decrements each cycle. The state exits to RUN in the cycle the counter equals 0.
  - m1_trap is ignored. It cannot be valid because the younger stages were flushed.
- pc_target is 0 whenever pc_redirect = 0.

## Timing
- Zero-cycle latency: stall, flush and redirect respond combinationally in the same cycle as their cause.
- A trap in cycle T produces:
  - pc_redirect in T;
  - DRAIN_CYCLES cycles of stall_if in T+1 through T+DRAIN_CYCLES;
  - the first fetch of the target allowed in T+DRAIN_CYCLES+1.
- Simultaneous events:
  - A trap with an ex_redirect: the trap wins, and ex_target is discarded.
  - Dmem wait with a trap: the trap is deferred until dmem_ready. m1_trap is held stable by the stall.
  - Load-use with imem wait: the union applies, so stall_if, stall_id, flush_ex and flush_id are all 1.
- Reset asserted mid-DMEM_WAIT or mid-TRAP_DRAIN forces RUN immediately, asynchronously.

## Structure
- pipe_hazard_ctrl_pkg holds:
  - the state enum typedef (RUN, DMEM_WAIT, TRAP_DRAIN), 2 bits;
  - the stage-count constants.
- One sub-module, pipe_hazard_cmp: combinational load-use comparator. Inputs are the rs/rd/valid signals; output is a hazard bit. It is instantiated once.

## Test plan
- ex_is_load=1, ex_rd=5, id_rs1=5, id_use_rs1=1 → stall_if/stall_id/flush_ex for 2 cycles as the load moves EX→M1→M2, then release. The same case with id_rs1=0 → no stall.
- ex_redirect=1, ex_target=0x0000_0100 → pc_redirect=1, pc_target=0x100, flush_id=flush_ex=1 for exactly one cycle.
- m1_trap=1, m1_trap_target=0x8000_0004, DRAIN_CYCLES=2 → redirect in cycle T, stall_if+flush_id in T+1 and T+2, RUN in T+3. A concurrent ex_redirect is ignored.
- m1_mem_access=1 with dmem_ready low for 3 cycles → stall_if..stall_m1 + flush_m2 held 3 cycles. A pending m1_trap redirects only in the cycle dmem_ready=1.
- rst pulsed during TRAP_DRAIN → all outputs 0 immediately; after release the state is RUN and no stall occurs.
- imem_ready=0 together with a load-use hazard → stall_if, stall_id, flush_ex and flush_id all 1.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned NUM_STAGES = 6;               // IF ID EX M1 M2 WB
  localparam int unsigned NUM_CTRL   = NUM_STAGES - 2;  // stall/flush lines per kind
  localparam int unsigned REG_W      = 5;
  localparam int unsigned XLEN       = 32;

  // stall vector: what is held; flush vector: which stage input is zeroed
  localparam int unsigned S_IF = 0;
  localparam int unsigned S_ID = 1;
  localparam int unsigned S_EX = 2;
  localparam int unsigned S_M1 = 3;
  localparam int unsigned F_ID = 0;
  localparam int unsigned F_EX = 1;
  localparam int unsigned F_M1 = 2;
  localparam int unsigned F_M2 = 3;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_DMEM_WAIT  = 2'd1,
    ST_TRAP_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_hazard_cmp.sv
// Load-use comparator: ID source registers against pending EX/M1 load destinations.
module pipe_hazard_cmp
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] m1_rd,
  input  logic             m1_is_load,
  output logic             hazard
);

  logic rs1_hit;
  logic rs2_hit;

  // x0 never carries a dependency
  assign rs1_hit = id_use_rs1 && (id_rs1 != '0) &&
                   ((ex_is_load && (ex_rd == id_rs1)) || (m1_is_load && (m1_rd == id_rs1)));
  assign rs2_hit = id_use_rs2 && (id_rs2 != '0) &&
                   ((ex_is_load && (ex_rd == id_rs2)) || (m1_is_load && (m1_rd == id_rs2)));

  assign hazard = rs1_hit || rs2_hit;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush/redirect controller for the six-stage pipeline.
//   state          | meaning
//   ST_RUN         | normal issue; priority dmem > trap > ex redirect > load-use/imem
//   ST_DMEM_WAIT   | M1 access outstanding, everything up to M1 held, bubble into M2
//   ST_TRAP_DRAIN  | post-trap bubbles while CSR state settles; fetch held
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] m1_rd,
  input  logic             ex_is_load,
  input  logic             m1_is_load,
  input  logic             ex_redirect,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             m1_trap,
  input  logic [XLEN-1:0]  m1_trap_target,
  input  logic             m1_mem_access,
  input  logic             dmem_ready,
  input  logic             imem_ready,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_m1,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             flush_m1,
  output logic             flush_m2,
  output logic             pc_redirect,
  output logic [XLEN-1:0]  pc_target
);

  localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DRAIN_INIT =
    (DRAIN_CYCLES > 0) ? CNT_W'(DRAIN_CYCLES - 1) : '0;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_CTRL-1:0]  stall_v, flush_v;
  logic                 redir_c;
  logic [XLEN-1:0]      target_c;
  logic                 load_use;
  logic                 dmem_wait;

  pipe_hazard_cmp u_cmp (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_rd      (ex_rd),
    .ex_is_load (ex_is_load),
    .m1_rd      (m1_rd),
    .m1_is_load (m1_is_load),
    .hazard     (load_use)
  );

  assign dmem_wait = m1_mem_access && !dmem_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_v  = '0;
    flush_v  = '0;
    redir_c  = 1'b0;
    target_c = '0;
    case (state_q)
      ST_TRAP_DRAIN: begin
        stall_v[S_IF] = 1'b1;
        flush_v[F_ID] = 1'b1;
        if (cnt_q == '0) state_d = ST_RUN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: begin
        if (dmem_wait) begin
          stall_v       = '1;
          flush_v[F_M2] = 1'b1;
          state_d       = ST_DMEM_WAIT;
        end else if (m1_trap) begin
          flush_v[F_ID] = 1'b1;
          flush_v[F_EX] = 1'b1;
          flush_v[F_M1] = 1'b1;
          redir_c       = 1'b1;
          target_c      = m1_trap_target;
          if (DRAIN_CYCLES == 0) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_TRAP_DRAIN;
            cnt_d   = DRAIN_INIT;
          end
        end else begin
          state_d = ST_RUN;
          if (ex_redirect) begin
            flush_v[F_ID] = 1'b1;
            flush_v[F_EX] = 1'b1;
            redir_c       = 1'b1;
            target_c      = ex_target;
          end else begin
            // load-use and imem wait are independent and combine
            if (load_use) begin
              stall_v[S_IF] = 1'b1;
              stall_v[S_ID] = 1'b1;
              flush_v[F_EX] = 1'b1;
            end
            if (!imem_ready) begin
              stall_v[S_IF] = 1'b1;
              flush_v[F_ID] = 1'b1;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_if    = !rst && stall_v[S_IF];
  assign stall_id    = !rst && stall_v[S_ID];
  assign stall_ex    = !rst && stall_v[S_EX];
  assign stall_m1    = !rst && stall_v[S_M1];
  assign flush_id    = !rst && flush_v[F_ID];
  assign flush_ex    = !rst && flush_v[F_EX];
  assign flush_m1    = !rst && flush_v[F_M1];
  assign flush_m2    = !rst && flush_v[F_M2];
  assign pc_redirect = !rst && redir_c;
  assign pc_target   = rst ? '0 : target_c;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with DRAIN_CYCLES = 2.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd, m1_rd;
  logic        id_use_rs1, id_use_rs2, ex_is_load, m1_is_load;
  logic        ex_redirect, m1_trap, m1_mem_access, dmem_ready, imem_ready;
  logic [31:0] ex_target, m1_trap_target;
  logic        stall_if, stall_id, stall_ex, stall_m1;
  logic        flush_id, flush_ex, flush_m1, flush_m2, pc_redirect;
  logic [31:0] pc_target;
  logic [8:0]  outv;

  int tests = 0;
  int fails = 0;

  // {stall_if,stall_id,stall_ex,stall_m1, flush_id,flush_ex,flush_m1,flush_m2, pc_redirect}
  localparam logic [8:0] O_NONE  = 9'b0000_0000_0;
  localparam logic [8:0] O_LU    = 9'b1100_0100_0;
  localparam logic [8:0] O_EXR   = 9'b0000_1100_1;
  localparam logic [8:0] O_TRAP  = 9'b0000_1110_1;
  localparam logic [8:0] O_DRAIN = 9'b1000_1000_0;
  localparam logic [8:0] O_IMEM  = 9'b1000_1000_0;
  localparam logic [8:0] O_DMEM  = 9'b1111_0001_0;
  localparam logic [8:0] O_LUIM  = 9'b1100_1100_0;

  assign outv = {stall_if, stall_id, stall_ex, stall_m1,
                 flush_id, flush_ex, flush_m1, flush_m2, pc_redirect};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.DRAIN_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .m1_rd(m1_rd), .ex_is_load(ex_is_load), .m1_is_load(m1_is_load),
    .ex_redirect(ex_redirect), .ex_target(ex_target),
    .m1_trap(m1_trap), .m1_trap_target(m1_trap_target),
    .m1_mem_access(m1_mem_access), .dmem_ready(dmem_ready), .imem_ready(imem_ready),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_m1(stall_m1),
    .flush_id(flush_id), .flush_ex(flush_ex), .flush_m1(flush_m1), .flush_m2(flush_m2),
    .pc_redirect(pc_redirect), .pc_target(pc_target)
  );

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rd = 0; m1_rd = 0; ex_is_load = 0; m1_is_load = 0;
    ex_redirect = 0; ex_target = 0; m1_trap = 0; m1_trap_target = 0;
    m1_mem_access = 0; dmem_ready = 1; imem_ready = 1;
  endtask

  // advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    imem_ready = 0; m1_trap = 1; m1_trap_target = 32'h1234_5678;
    #3;
    tests++;
    if (outv !== O_NONE || pc_target !== 32'h0) begin
      $display("FAIL reset_outputs: got %b/%h want %b/%h", outv, pc_target, O_NONE, 32'h0);
      fails++;
    end
    cyc();
    rst = 1'b0;
    idle();
    #2;
    tests++;
    if (outv !== O_NONE) begin
      $display("FAIL reset_idle: got %b want %b", outv, O_NONE);
      fails++;
    end
    cyc();
  endtask

  task automatic test_load_use();
    idle();
    ex_is_load = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    #2;
    tests++;
    if (outv !== O_LU) begin
      $display("FAIL lu_ex_load: got %b want %b", outv, O_LU); fails++;
    end
    cyc();
    ex_is_load = 0; ex_rd = 0; m1_is_load = 1; m1_rd = 5;
    #2;
    tests++;
    if (outv !== O_LU) begin
      $display("FAIL lu_m1_load: got %b want %b", outv, O_LU); fails++;
    end
    cyc();
    m1_is_load = 0; m1_rd = 0;
    #2;
    tests++;
    if (outv !== O_NONE) begin
      $display("FAIL lu_release: got %b want %b", outv, O_NONE); fails++;
    end
    cyc();
    ex_is_load = 1; ex_rd = 0; id_rs1 = 0;
    #2;
    tests++;
    if (outv !== O_NONE) begin
      $display("FAIL lu_x0: got %b want %b", outv, O_NONE); fails++;
    end
    cyc();
    idle();
    m1_is_load = 1; m1_rd = 9; id_rs2 = 9; id_use_rs2 = 1; id_rs1 = 9;
    #2;
    tests++;
    if (outv !== O_LU) begin
      $display("FAIL lu_rs2_m1: got %b want %b", outv, O_LU); fails++;
    end
    cyc();
    id_use_rs2 = 0;
    #2;
    tests++;
    if (outv !== O_NONE) begin
      $display("FAIL lu_unused_src: got %b want %b", outv, O_NONE); fails++;
    end
    cyc();
  endtask

  task automatic test_ex_redirect();
    idle();
    ex_redirect = 1; ex_target = 32'h0000_0100;
    ex_is_load = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1;
    #2;
    tests++;
    if (outv !== O_EXR || pc_target !== 32'h0000_0100) begin
      $display("FAIL ex_redirect: got %b/%h want %b/%h", outv, pc_target, O_EXR, 32'h100);
      fails++;
    end
    cyc();
    idle();
    #2;
    tests++;
    if (outv !== O_NONE || pc_target !== 32'h0) begin
      $display("FAIL ex_redirect_once: got %b/%h want %b/%h", outv, pc_target, O_NONE, 32'h0);
      fails++;
    end
    cyc();
  endtask

  task automatic test_trap();
    idle();
    m1_trap = 1; m1_trap_target = 32'h8000_0004;
    ex_redirect = 1; ex_target = 32'h0000_0100;
    #2;
    tests++;
    if (outv !== O_TRAP || pc_target !== 32'h8000_0004) begin
      $display("FAIL trap_T: got %b/%h want %b/%h", outv, pc_target, O_TRAP, 32'h8000_0004);
      fails++;
    end
    cyc();
    m1_trap = 0;
    ex_is_load = 1; ex_rd = 7; id_rs1 = 7; id_use_rs1 = 1;
    #2;
    tests++;
    if (outv !== O_DRAIN || pc_target !== 32'h0) begin
      $display("FAIL trap_T1: got %b/%h want %b/%h", outv, pc_target, O_DRAIN, 32'h0);
      fails++;
    end
    cyc();
    #1;
    tests++;
    if (outv !== O_DRAIN) begin
      $display("FAIL trap_T2: got %b want %b", outv, O_DRAIN); fails++;
    end
    cyc();
    ex_is_load = 0; ex_rd = 0;
    #2;
    tests++;
    if (outv !== O_EXR || pc_target !== 32'h0000_0100) begin
      $display("FAIL trap_T3_run: got %b/%h want %b/%h", outv, pc_target, O_EXR, 32'h100);
      fails++;
    end
    cyc();
    idle();
  endtask

  task automatic test_dmem_wait();
    idle();
    m1_mem_access = 1; dmem_ready = 0; m1_trap = 1; m1_trap_target = 32'h0000_0200;
    for (int i = 0; i < 3; i++) begin
      #2;
      tests++;
      if (outv !== O_DMEM || pc_target !== 32'h0) begin
        $display("FAIL dmem_wait_%0d: got %b/%h want %b/%h", i, outv, pc_target, O_DMEM, 32'h0);
        fails++;
      end
      cyc();
    end
    dmem_ready = 1;
    #2;
    tests++;
    if (outv !== O_TRAP || pc_target !== 32'h0000_0200) begin
      $display("FAIL dmem_then_trap: got %b/%h want %b/%h", outv, pc_target, O_TRAP, 32'h200);
      fails++;
    end
    cyc();
    idle();
    for (int i = 0; i < 2; i++) begin
      #2;
      tests++;
      if (outv !== O_DRAIN) begin
        $display("FAIL dmem_drain_%0d: got %b want %b", i, outv, O_DRAIN); fails++;
      end
      cyc();
    end
    #2;
    tests++;
    if (outv !== O_NONE) begin
      $display("FAIL dmem_drain_exit: got %b want %b", outv, O_NONE); fails++;
    end
    cyc();
  endtask

  task automatic test_reset_in_drain();
    idle();
    m1_trap = 1; m1_trap_target = 32'h0000_0040;
    cyc();
    m1_trap = 0;
    #2;
    tests++;
    if (outv !== O_DRAIN) begin
      $display("FAIL rst_drain_pre: got %b want %b", outv, O_DRAIN); fails++;
    end
    rst = 1'b1;
    #1;
    tests++;
    if (outv !== O_NONE) begin
      $display("FAIL rst_drain_async: got %b want %b", outv, O_NONE); fails++;
    end
    cyc();
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if (outv !== O_NONE) begin
      $display("FAIL rst_drain_after: got %b want %b", outv, O_NONE); fails++;
    end
    cyc();
    #2;
    tests++;
    if (outv !== O_NONE) begin
      $display("FAIL rst_drain_run: got %b want %b", outv, O_NONE); fails++;
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    idle();
    imem_ready = 0; ex_is_load = 1; ex_rd = 12; id_rs2 = 12; id_use_rs2 = 1;
    #2;
    tests++;
    if (outv !== O_LUIM) begin
      $display("FAIL lu_plus_imem: got %b want %b", outv, O_LUIM); fails++;
    end
    cyc();
    ex_is_load = 0;
    #2;
    tests++;
    if (outv !== O_IMEM) begin
      $display("FAIL imem_only: got %b want %b", outv, O_IMEM); fails++;
    end
    cyc();
    imem_ready = 1; ex_is_load = 1; m1_mem_access = 1; dmem_ready = 0;
    #2;
    tests++;
    if (outv !== O_DMEM) begin
      $display("FAIL dmem_over_lu: got %b want %b", outv, O_DMEM); fails++;
    end
    cyc();
    idle();
    #2;
    tests++;
    if (outv !== O_NONE) begin
      $display("FAIL dmem_release: got %b want %b", outv, O_NONE); fails++;
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_ex_redirect();
    test_trap();
    test_dmem_wait();
    test_reset_in_drain();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, limit 100000 reached");
    $fatal(1, "timeout");
  end

endmodule
